// File: rtl/mux21b_arb.sv
// Round-robin 2:1 arbiter + one-entry output register driving the mux21b select; MUX21B_ARB_BURST_EN allows bursts.
// Latency: 1 cycle from accept to y_valid/y_data; full 1 transfer/cycle throughput.
// Backpressure: both readies drop while y_valid & ~y_ready; s still tracks the grant.
module mux21b_arb #(
    parameter int W        = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         s,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t       state_q, state_d;
    logic [W-1:0] y_data_q, y_data_d;
    logic         last_q, last_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         load;
    logic         g;
    logic         xfer;

    always_comb begin
        load = (state_q == EMPTY) | y_ready;
        g    = last_q;
        unique case ({a_valid, b_valid})
            2'b10:   g = 1'b0;
            2'b01:   g = 1'b1;
            2'b00:   g = last_q;
            default: begin
`ifdef MUX21B_ARB_BURST_EN
                // cnt==0 means nobody owns a burst yet, so fall back to alternation.
                g = ((cnt_q != 4'd0) && (cnt_q < HOLD)) ? last_q : ~last_q;
`else
                g = ~last_q;
`endif
            end
        endcase
        // Readies are gated by reset so no handshake completes while held in reset.
        a_ready = rst_n & load & ~g;
        b_ready = rst_n & load & g;
        s       = g;
        xfer    = (a_valid & a_ready) | (b_valid & b_ready);
    end

    always_comb begin
        state_d  = state_q;
        y_data_d = y_data_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (load) begin
            if (xfer) begin
                state_d  = FULL;
                y_data_d = g ? b_data : a_data;
                last_d   = g;
                if (g == last_q)
                    cnt_d = (cnt_q >= HOLD) ? HOLD : cnt_q + 4'd1;
                else
                    cnt_d = 4'd1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            y_data_q <= '0;
            last_q   <= 1'b1;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y_data  = y_data_q;

endmodule
